// File: rtl/binary_calc_engine.sv
// Binary calculator engine: ALU execute, result memory store/read and SIZE-bit serial transmit.
// Optional trailing parity chunk is enabled by defining BINARY_CALC_PARITY_EN.

module binary_calc_engine #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SIZE   = 4,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              InputKey,
  input  logic              ValidCmd,
  input  logic              RW,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] InA,
  input  logic [DATA_W-1:0] InB,
  input  logic [3:0]        Sel,
  input  logic              ConfigDiv,
  input  logic [31:0]       Din,
  output logic              DoutValid,
  output logic [SIZE-1:0]   DataOut,
  output logic              ClkTx,
  output logic              CalcBusy,
  output logic              CalcActive,
  output logic              CalcMode
);

  localparam int unsigned RES_W = 2 * DATA_W;
  localparam int unsigned NC    = RES_W / SIZE;
  localparam int unsigned DEPTH = 1 << ADDR_W;
`ifdef BINARY_CALC_PARITY_EN
  localparam int unsigned NC_TOT = NC + 1;
`else
  localparam int unsigned NC_TOT = NC;
`endif
  localparam int unsigned IDX_W = (NC_TOT > 1) ? $clog2(NC_TOT) : 1;

  if ((RES_W % SIZE) != 0) begin : g_size_check
    $error("binary_calc_engine: 2*DATA_W must be a multiple of SIZE");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_TX   = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_key_d;
  logic              r_active;
  logic              r_mode;
  logic [7:0]        r_div;
  logic [7:0]        r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic              r_busy;
  logic              r_dout_valid;
  logic              r_clk_tx;
  logic [SIZE-1:0]   r_data_out;
  logic [RES_W-1:0]  r_word;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [3:0]        r_sel;
  logic [RES_W-1:0]  r_din;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rw;
  logic [DEPTH-1:0]  r_vld;
  logic [RES_W-1:0]  r_mem [DEPTH];
`ifdef BINARY_CALC_PARITY_EN
  logic              r_par;
`endif

  logic              w_key_rise;
  logic              w_accept;
  logic              w_mem_we;
  logic [RES_W-1:0]  w_result;
  logic [RES_W-1:0]  w_mem_rd;
  logic [RES_W-1:0]  w_word_src;
  logic [RES_W-1:0]  w_word_shl;
  logic [RES_W-1:0]  w_a_ext;
  logic [RES_W-1:0]  w_b_ext;
  logic [DATA_W-1:0] w_not_a;
  logic [DATA_W-1:0] w_rotl;
  logic [DATA_W-1:0] w_rotr;
  logic [31:0]       w_rot_amt;
  logic [SIZE-1:0]   w_next_chunk;
  logic              w_unused_din;

  assign w_key_rise = InputKey & ~r_key_d;
  assign w_accept   = ValidCmd & r_active & ~r_busy;
  assign w_mem_we   = (r_state == S_EXEC) & r_rw & r_mode;

  // Operand shaping for the ALU; rotates wrap within DATA_W bits
  assign w_a_ext   = RES_W'(r_a);
  assign w_b_ext   = RES_W'(r_b);
  assign w_not_a   = ~r_a;
  assign w_rot_amt = 32'(r_b[3:0]) % DATA_W;
  assign w_rotl    = (r_a << w_rot_amt) | (r_a >> (DATA_W - w_rot_amt));
  assign w_rotr    = (r_a >> w_rot_amt) | (r_a << (DATA_W - w_rot_amt));

  always_comb begin
    w_result = '0;
    case (r_sel)
      4'd0:  w_result = w_a_ext + w_b_ext;
      4'd1:  w_result = w_a_ext - w_b_ext;
      4'd2:  w_result = w_a_ext * w_b_ext;
      4'd3:  w_result = w_a_ext & w_b_ext;
      4'd4:  w_result = w_a_ext | w_b_ext;
      4'd5:  w_result = w_a_ext ^ w_b_ext;
      4'd6:  w_result = RES_W'(w_not_a);
      4'd7:  w_result = w_a_ext << r_b[3:0];
      4'd8:  w_result = w_a_ext >> r_b[3:0];
      4'd9:  w_result = RES_W'(w_rotl);
      4'd10: w_result = RES_W'(w_rotr);
      4'd11: w_result = RES_W'(r_a < r_b);
      4'd12: w_result = RES_W'(r_a == r_b);
      4'd13: w_result = w_a_ext;
      4'd14: w_result = w_b_ext;
      default: w_result = r_din;
    endcase
  end

  // Entries never written since reset read back as zero
  assign w_mem_rd   = r_vld[r_addr] ? r_mem[r_addr] : '0;
  assign w_word_src = r_rw ? w_result : w_mem_rd;
  assign w_word_shl = r_word << SIZE;

`ifdef BINARY_CALC_PARITY_EN
  assign w_next_chunk = (r_idx == IDX_W'(NC - 1)) ? SIZE'(r_par) : w_word_shl[RES_W-1 -: SIZE];
`else
  assign w_next_chunk = w_word_shl[RES_W-1 -: SIZE];
`endif

  assign w_unused_din = ^Din;

  always_ff @(posedge Clk) begin
    if (!Reset && w_mem_we) begin
      r_mem[r_addr] <= w_result;
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= S_IDLE;
      r_key_d      <= 1'b0;
      r_active     <= 1'b0;
      r_mode       <= 1'b0;
      r_div        <= 8'd1;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_busy       <= 1'b0;
      r_dout_valid <= 1'b0;
      r_clk_tx     <= 1'b0;
      r_data_out   <= '0;
      r_word       <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_sel        <= '0;
      r_din        <= '0;
      r_addr       <= '0;
      r_rw         <= 1'b0;
      r_vld        <= '0;
`ifdef BINARY_CALC_PARITY_EN
      r_par        <= 1'b0;
`endif
    end else begin
      r_key_d <= InputKey;
      if (w_key_rise && !r_busy) begin
        r_active <= ~r_active;
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (ConfigDiv) begin
              r_div  <= Din[7:0];
              r_mode <= Din[8];
            end else begin
              r_a     <= InA;
              r_b     <= InB;
              r_sel   <= Sel;
              r_din   <= RES_W'(Din);
              r_addr  <= Addr;
              r_rw    <= RW;
              r_busy  <= 1'b1;
              r_state <= S_EXEC;
            end
          end
        end

        S_EXEC: begin
          if (r_rw && r_mode) begin
            r_vld[r_addr] <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= S_IDLE;
          end else begin
            r_word       <= w_word_src;
            r_data_out   <= w_word_src[RES_W-1 -: SIZE];
            r_dout_valid <= 1'b1;
            r_clk_tx     <= 1'b0;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_state      <= S_TX;
`ifdef BINARY_CALC_PARITY_EN
            r_par        <= ^w_word_src;
`endif
          end
        end

        S_TX: begin
          // Each phase lasts DIV+1 cycles; a chunk is one low phase then one high phase
          if (r_cnt == r_div) begin
            r_cnt <= '0;
            if (!r_clk_tx) begin
              r_clk_tx <= 1'b1;
            end else if (r_idx == IDX_W'(NC_TOT - 1)) begin
              r_clk_tx     <= 1'b0;
              r_dout_valid <= 1'b0;
              r_busy       <= 1'b0;
              r_data_out   <= '0;
              r_state      <= S_IDLE;
            end else begin
              r_clk_tx   <= 1'b0;
              r_idx      <= r_idx + IDX_W'(1);
              r_word     <= w_word_shl;
              r_data_out <= w_next_chunk;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign DoutValid  = r_dout_valid;
  assign DataOut    = r_data_out;
  assign ClkTx      = r_clk_tx;
  assign CalcBusy   = r_busy;
  assign CalcActive = r_active;
  assign CalcMode   = r_mode;

endmodule

// File: tb/tb_binary_calc_engine.sv
// Self-checking bench for binary_calc_engine: transaction-level reference model compared every
// cycle, plus directed scenarios with literal expectations. Honours BINARY_CALC_PARITY_EN.

module tb_binary_calc_engine;

  localparam int DATA_W = 8;
  localparam int SIZE   = 4;
  localparam int ADDR_W = 8;
`ifdef BINARY_CALC_PARITY_EN
  localparam int NCH = 5;
`else
  localparam int NCH = 4;
`endif

  logic              Clk;
  logic              Reset;
  logic              InputKey;
  logic              ValidCmd;
  logic              RW;
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] InA;
  logic [DATA_W-1:0] InB;
  logic [3:0]        Sel;
  logic              ConfigDiv;
  logic [31:0]       Din;
  logic              DoutValid;
  logic [SIZE-1:0]   DataOut;
  logic              ClkTx;
  logic              CalcBusy;
  logic              CalcActive;
  logic              CalcMode;

  binary_calc_engine #(.DATA_W(DATA_W), .SIZE(SIZE), .ADDR_W(ADDR_W)) dut (
    .Clk(Clk), .Reset(Reset), .InputKey(InputKey), .ValidCmd(ValidCmd), .RW(RW),
    .Addr(Addr), .InA(InA), .InB(InB), .Sel(Sel), .ConfigDiv(ConfigDiv), .Din(Din),
    .DoutValid(DoutValid), .DataOut(DataOut), .ClkTx(ClkTx), .CalcBusy(CalcBusy),
    .CalcActive(CalcActive), .CalcMode(CalcMode)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] calc(input logic [3:0] sel, input logic [7:0] a,
                                       input logic [7:0] b, input logic [31:0] din);
    logic [15:0] aa;
    logic [15:0] bb;
    logic [15:0] dbl;
    logic [15:0] tmp;
    int s;
    aa  = {8'h00, a};
    bb  = {8'h00, b};
    dbl = {a, a};
    s   = int'(b[3:0]) % 8;
    case (sel)
      4'd0:  return aa + bb;
      4'd1:  return aa - bb;
      4'd2:  return aa * bb;
      4'd3:  return aa & bb;
      4'd4:  return aa | bb;
      4'd5:  return aa ^ bb;
      4'd6:  return {8'h00, ~a};
      4'd7:  return aa << b[3:0];
      4'd8:  return aa >> b[3:0];
      4'd9:  begin tmp = dbl << s; return {8'h00, tmp[15:8]}; end
      4'd10: begin tmp = dbl >> s; return {8'h00, tmp[7:0]}; end
      4'd11: return (a < b) ? 16'd1 : 16'd0;
      4'd12: return (a == b) ? 16'd1 : 16'd0;
      4'd13: return aa;
      4'd14: return bb;
      default: return din[15:0];
    endcase
  endfunction

  function automatic logic [3:0] chunk_of(input logic [15:0] word, input int k);
    logic [15:0] tmp;
    if (k >= 4) return {3'b000, ^word};
    tmp = word >> (12 - 4 * k);
    return tmp[3:0];
  endfunction

  // Transaction-level reference: command phases and transmit offset in Clk cycles
  typedef enum {M_IDLE, M_STORE, M_LOAD, M_TX} mst_t;
  mst_t        m_st = M_IDLE;
  bit          m_active, m_mode, m_key_d, m_busy_now, m_acc, m_live;
  int          m_div = 1;
  int          m_off, m_addr, m_per;
  logic [15:0] m_word;
  logic [15:0] m_mem [int];
  bit          e_dv, e_busy, e_clk;
  logic [3:0]  e_data;

  always @(posedge Clk) begin
    if (Reset) begin
      m_st = M_IDLE; m_active = 0; m_mode = 0; m_div = 1; m_key_d = 0; m_off = 0;
      m_mem.delete();
    end else begin
      m_busy_now = (m_st != M_IDLE);
      m_acc = ValidCmd && m_active && !m_busy_now;
      if (InputKey && !m_key_d && !m_busy_now) m_active = !m_active;
      m_key_d = InputKey;
      case (m_st)
        M_IDLE: if (m_acc) begin
          if (ConfigDiv) begin
            m_div = int'(Din[7:0]); m_mode = Din[8];
          end else begin
            m_addr = int'(Addr);
            if (RW) m_word = calc(Sel, InA, InB, Din);
            else m_word = m_mem.exists(m_addr) ? m_mem[m_addr] : 16'h0000;
            m_st = (RW && m_mode) ? M_STORE : M_LOAD;
          end
        end
        M_STORE: begin m_mem[m_addr] = m_word; m_st = M_IDLE; end
        M_LOAD:  begin m_st = M_TX; m_off = 0; end
        M_TX: begin
          m_off++;
          if (m_off == NCH * 2 * (m_div + 1)) m_st = M_IDLE;
        end
      endcase
    end
    e_busy = (m_st != M_IDLE);
    e_dv   = (m_st == M_TX);
    e_clk  = 0;
    e_data = 4'h0;
    if (m_st == M_TX) begin
      m_per  = 2 * (m_div + 1);
      e_clk  = (m_off % m_per) >= (m_div + 1);
      e_data = chunk_of(m_word, m_off / m_per);
    end
    m_live = 1;
  end

  always @(negedge Clk) begin
    if (m_live) begin
      chk("DoutValid",  32'(DoutValid),  32'(e_dv));
      chk("CalcBusy",   32'(CalcBusy),   32'(e_busy));
      chk("ClkTx",      32'(ClkTx),      32'(e_clk));
      chk("DataOut",    32'(DataOut),    32'(e_data));
      chk("CalcActive", 32'(CalcActive), 32'(m_active));
      chk("CalcMode",   32'(CalcMode),   32'(m_mode));
    end
  end

  logic [3:0] cap[$];
  int  dv_cycles, busy_cycles;
  bit  cap_prev;

  always @(negedge Clk) begin
    if (DoutValid) dv_cycles++;
    if (CalcBusy) busy_cycles++;
    if (DoutValid && ClkTx && !cap_prev) cap.push_back(DataOut);
    cap_prev = ClkTx;
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic cmd(input bit cfg, input bit rw, input logic [3:0] sel, input logic [7:0] a,
                     input logic [7:0] b, input logic [7:0] addr, input logic [31:0] din);
    ValidCmd = 1; ConfigDiv = cfg; RW = rw; Sel = sel; InA = a; InB = b; Addr = addr; Din = din;
    step();
    ValidCmd = 0; ConfigDiv = 0;
  endtask

  task automatic key_pulse();
    InputKey = 1; step();
    InputKey = 0; step();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((CalcBusy || DoutValid) && n < 2000) begin step(); n++; end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL %s timeout: still busy after %0d cycles", name, n);
    end
  endtask

  task automatic clear_cap();
    cap.delete(); dv_cycles = 0; busy_cycles = 0;
  endtask

  task automatic chk_chunks(input string name, input int n, input logic [19:0] v);
    logic [19:0] t;
    chk({name, "_count"}, 32'(cap.size()), 32'(n));
    for (int i = 0; i < n && i < cap.size(); i++) begin
      t = v >> (4 * (n - 1 - i));
      chk(name, 32'(cap[i]), 32'(t[3:0]));
    end
  endtask

  initial begin
    Reset = 1; InputKey = 0; ValidCmd = 0; RW = 0; Addr = 0; InA = 0; InB = 0;
    Sel = 0; ConfigDiv = 0; Din = 0;
    repeat (3) step();
    chk("rst_dv",     32'(DoutValid),  0);
    chk("rst_busy",   32'(CalcBusy),   0);
    chk("rst_active", 32'(CalcActive), 0);
    chk("rst_mode",   32'(CalcMode),   0);
    chk("rst_clktx",  32'(ClkTx),      0);
    chk("rst_data",   32'(DataOut),    0);
    Reset = 0;
    step();

    chk("model_add",  32'(calc(4'd0,  8'hFF, 8'h01, 0)), 32'h0100);
    chk("model_mul",  32'(calc(4'd2,  8'd12, 8'd13, 0)), 32'h009C);
    chk("model_sub",  32'(calc(4'd1,  8'h00, 8'h01, 0)), 32'hFFFF);
    chk("model_rotl", 32'(calc(4'd9,  8'h81, 8'h01, 0)), 32'h0003);
    chk("model_rotr", 32'(calc(4'd10, 8'h81, 8'h01, 0)), 32'h00C0);
    chk("model_not",  32'(calc(4'd6,  8'h0F, 8'h00, 0)), 32'h00F0);
    chk("model_shl",  32'(calc(4'd7,  8'h81, 8'h04, 0)), 32'h0810);

    key_pulse();
    chk("key_on", 32'(CalcActive), 1);

    // Direct transmit, DIV=1: 0x0100
    clear_cap();
    cmd(0, 1, 4'd0, 8'hFF, 8'h01, 8'd0, 0);
    wait_idle("add_tx");
`ifdef BINARY_CALC_PARITY_EN
    chk_chunks("add_chunks", 5, 20'h01001);
    chk("add_dv_cycles", 32'(dv_cycles), 20);
`else
    chk_chunks("add_chunks", 4, 20'h00100);
    chk("add_dv_cycles", 32'(dv_cycles), 16);
`endif

    // Store mode, DIV=0, then read back
    cmd(1, 0, 4'd0, 0, 0, 0, 32'h100);
    chk("cfg_mode", 32'(CalcMode), 1);
    clear_cap();
    cmd(0, 1, 4'd2, 8'd12, 8'd13, 8'd5, 0);
    wait_idle("mul_store");
    chk("store_busy_cycles", 32'(busy_cycles), 1);
    chk("store_dv_cycles",   32'(dv_cycles),   0);
    clear_cap();
    cmd(0, 0, 4'd0, 0, 0, 8'd5, 0);
    wait_idle("read5");
`ifdef BINARY_CALC_PARITY_EN
    chk_chunks("read5_chunks", 5, 20'h009C0);
`else
    chk_chunks("read5_chunks", 4, 20'h0009C);
`endif

    // Commands during TX and while inactive are dropped
    cmd(1, 0, 4'd0, 0, 0, 0, 32'h001);
    clear_cap();
    cmd(0, 1, 4'd14, 8'h00, 8'h5A, 8'd0, 0);
    repeat (5) step();
    cmd(0, 0, 4'd13, 8'h77, 8'h00, 8'd5, 0);
    wait_idle("drop_tx");
`ifdef BINARY_CALC_PARITY_EN
    chk_chunks("drop_chunks", 5, 20'h005A0);
`else
    chk_chunks("drop_chunks", 4, 20'h0005A);
`endif
    key_pulse();
    chk("key_off", 32'(CalcActive), 0);
    clear_cap();
    cmd(0, 1, 4'd0, 8'h01, 8'h01, 8'd0, 0);
    repeat (3) step();
    chk("inactive_busy", 32'(busy_cycles), 0);
    chk("inactive_dv",   32'(dv_cycles),   0);
    key_pulse();
    clear_cap();
    cmd(0, 0, 4'd0, 0, 0, 8'd5, 0);
    wait_idle("reread5");
`ifdef BINARY_CALC_PARITY_EN
    chk_chunks("reread5_chunks", 5, 20'h009C0);
`else
    chk_chunks("reread5_chunks", 4, 20'h0009C);
`endif

    // DIV=0: 0 - 1 = 0xFFFF
    cmd(1, 0, 4'd0, 0, 0, 0, 32'h000);
    clear_cap();
    cmd(0, 1, 4'd1, 8'h00, 8'h01, 8'd0, 0);
    wait_idle("sub_tx");
`ifdef BINARY_CALC_PARITY_EN
    chk_chunks("sub_chunks", 5, 20'hFFFF0);
    chk("sub_dv_cycles", 32'(dv_cycles), 10);
`else
    chk_chunks("sub_chunks", 4, 20'h0FFFF);
    chk("sub_dv_cycles", 32'(dv_cycles), 8);
`endif

    clear_cap();
    cmd(0, 1, 4'd13, 8'h07, 8'h00, 8'd0, 0);
    wait_idle("pass_a");
`ifdef BINARY_CALC_PARITY_EN
    chk_chunks("pass_a_chunks", 5, 20'h00071);
`else
    chk_chunks("pass_a_chunks", 4, 20'h00007);
`endif

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      ValidCmd  = ($urandom % 4) == 0;
      ConfigDiv = ($urandom % 8) == 0;
      RW        = 1'($urandom % 2);
      Sel       = 4'($urandom);
      InA       = 8'($urandom);
      InB       = 8'($urandom);
      Addr      = 8'($urandom % 8);
      Din       = $urandom;
      if (ConfigDiv) Din[7:0] = 8'($urandom % 3);
      if (($urandom % 20) == 0) InputKey = ~InputKey;
      Reset     = ($urandom % 700) == 0;
      step();
    end
    Reset = 0; ValidCmd = 0; ConfigDiv = 0; InputKey = 0;
    step();
    wait_idle("random_drain");

    // Reset during the third chunk aborts and clears memory
    Reset = 1; step(); Reset = 0; step();
    key_pulse();
    cmd(1, 0, 4'd0, 0, 0, 0, 32'h101);
    cmd(0, 1, 4'd13, 8'h33, 8'h00, 8'd9, 0);
    wait_idle("store9");
    cmd(1, 0, 4'd0, 0, 0, 0, 32'h001);
    clear_cap();
    cmd(0, 0, 4'd0, 0, 0, 8'd9, 0);
    begin
      int n = 0;
      while (!(cap.size() == 2 && DoutValid && !ClkTx) && n < 200) begin step(); n++; end
      checks++;
      if (n >= 200) begin
        errors++;
        $display("FAIL third_chunk timeout: waited %0d cycles", n);
      end
    end
    Reset = 1;
    step();
    chk("abort_dv",     32'(DoutValid),  0);
    chk("abort_busy",   32'(CalcBusy),   0);
    chk("abort_clktx",  32'(ClkTx),      0);
    chk("abort_data",   32'(DataOut),    0);
    chk("abort_active", 32'(CalcActive), 0);
    Reset = 0;
    step();
    key_pulse();
    clear_cap();
    cmd(0, 0, 4'd0, 0, 0, 8'd9, 0);
    wait_idle("read9_after_reset");
    chk_chunks("read9_chunks", NCH, 20'h00000);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/binary_calc_engine.md
BINARY_CALC_ENGINE -- requirements
Module: binary_calc_engine

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter DATA_W, 8: operand width; RES_W = 2*DATA_W is derived, not overridable.
REQ-003 Parameter SIZE, 4: DataOut lane width; RES_W SHALL be a multiple of SIZE (elaboration error otherwise).
REQ-004 Parameter ADDR_W, 8: result memory depth 2^ADDR_W words of RES_W bits.
REQ-005 Clk  in  1  system clock.
REQ-006 Reset  in  1  synchronous active-high reset.
REQ-007 InputKey  in  1  activation key; each rising edge toggles CalcActive.
REQ-008 ValidCmd  in  1  command strobe, one cycle per command.
REQ-009 RW  in  1  1 = execute, 0 = read memory.
REQ-010 Addr  in  ADDR_W  memory address.
REQ-011 InA, InB  in  DATA_W each  operands.
REQ-012 Sel  in  4  operation select.
REQ-013 ConfigDiv  in  1  qualifies ValidCmd as a configuration write.
REQ-014 Din  in  32  configuration/load data.
REQ-015 DoutValid  out  1  serial chunk stream active.
REQ-016 DataOut  out  SIZE  current result chunk.
REQ-017 ClkTx  out  1  divided transmit clock.
REQ-018 CalcBusy  out  1  command in progress.
REQ-019 CalcActive  out  1  engine enabled.
REQ-020 CalcMode  out  1  0 = direct transmit, 1 = store to memory.

Function
REQ-021 FSM states IDLE, EXEC, TX; IDLE->EXEC on accepted execute/read, EXEC->TX (direct or read) or EXEC->IDLE (store), TX->IDLE after last chunk.
REQ-022 Accept = ValidCmd & CalcActive & !CalcBusy; ValidCmd otherwise SHALL be dropped with no state change.
REQ-023 ConfigDiv=1 on accept: DIV <= Din[7:0], CalcMode <= Din[8], single cycle, no busy, no transmit.
REQ-024 Execute result (RES_W bits, zero-extended operands): Sel 0 A+B, 1 A-B modulo 2^RES_W, 2 A*B, 3 A&B, 4 A|B, 5 A^B, 6 ~A (DATA_W bits), 7 A<<InB[3:0], 8 A>>InB[3:0], 9 rotl DATA_W, 10 rotr DATA_W, 11 A<B, 12 A==B, 13 A, 14 B, 15 Din truncated/zero-extended to RES_W.
REQ-025 Result/memory word SHALL be registered in EXEC one cycle after accept; CalcBusy high from cycle after accept.
REQ-026 CalcMode=1 execute: mem[Addr] <= result in EXEC, CalcBusy high exactly 1 cycle, DoutValid stays 0.
REQ-027 CalcMode=0 execute or RW=0 read (mem[Addr]): word transmitted as NC = RES_W/SIZE chunks, most significant chunk first.
REQ-028 In TX, ClkTx starts low and toggles every DIV+1 Clk cycles; DataOut changes only with ClkTx low and is stable while ClkTx high; each chunk occupies one full low+high period.
REQ-029 DoutValid high for all TX cycles (NC*2*(DIV+1)); DoutValid and CalcBusy fall together on the cycle after the last high phase ends.
REQ-030 Outside TX: ClkTx = 0, DataOut = 0, DoutValid = 0.
REQ-031 InputKey edges while CalcBusy SHALL be ignored; edge detector still tracks level.
REQ-032 DIV/CalcMode SHALL not change during TX (config writes rejected while busy per REQ-022).
REQ-033 Simultaneous ValidCmd and InputKey rising edge: toggle applies, command evaluated with pre-toggle CalcActive.
REQ-034 Reading unwritten memory SHALL return 0.

Reset
REQ-035 Reset SHALL return FSM to IDLE, CalcActive 0, CalcMode 0, DIV 1, all outputs 0, key edge register 0; mid-TX reset aborts within the same cycle.
REQ-036 Memory contents SHALL be cleared by reset via a valid-bit array (reads of invalid entries return 0).

Configuration
REQ-037 Macro BINARY_CALC_PARITY_EN defined: TX appends one extra chunk after data, bit 0 = XOR of all RES_W bits, other bits 0; DoutValid covers NC+1 chunks.
REQ-038 Macro undefined: exactly NC chunks, no parity logic present.

Verification
REQ-039 Reset, InputKey pulse, execute Sel=0 InA=8'hFF InB=8'h01 CalcMode=0 DIV=1 -> chunks 0,1,0,0 MSB-first, each 4 Clk cycles, DoutValid 16 cycles.
REQ-040 Config Din=32'h100 then execute Sel=2 InA=8'd12 InB=8'd13 Addr=5 -> CalcBusy 1 cycle, no DoutValid; read Addr=5 -> chunks 0,0,9,C.
REQ-041 ValidCmd during TX, and ValidCmd with CalcActive=0 -> dropped, stream and memory unchanged.
REQ-042 Reset asserted on 3rd TX chunk -> next cycle all outputs 0, FSM IDLE, read of prior address returns 0.
REQ-043 BINARY_CALC_PARITY_EN, Sel=13 InA=8'h07 -> chunks 0,0,0,7 then 1; without macro four chunks only.
REQ-044 DIV=0, Sel=1 InA=0 InB=1 -> chunks F,F,F,F, ClkTx toggling every cycle, 8 TX cycles.
